// File: rtl/react_test_ctrl_pkg.sv
// Shared phase/mode codes and helpers for the reaction-time benchmark.
// Imported by react_test_ctrl and its sub-modules.
package react_test_ctrl_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_WAIT   = 3'd1,
    PH_GO     = 3'd2,
    PH_RESULT = 3'd3,
    PH_EARLY  = 3'd4,
    PH_AVG    = 3'd5,
    PH_DONE   = 3'd6
  } phase_e;

  localparam logic [1:0] MODE_MENU  = 2'd0;
  localparam logic [1:0] MODE_REACT = 2'd1;
  localparam logic [1:0] MODE_CHIMP = 2'd2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [13:0] sat14(input logic [16:0] x);
    return (x > 17'd16383) ? 14'h3FFF : x[13:0];
  endfunction

endpackage

// File: rtl/react_test_ctrl_seq_div.sv
// seq_div: 17-bit restoring divider by a 3-bit divisor, one quotient bit/cycle.
// Ports: clk, iResetn (sync, low), iStart, iDividend, iDivisor, oQuot, oDone pulse.
module seq_div (
  input  logic        clk,
  input  logic        iResetn,
  input  logic        iStart,
  input  logic [16:0] iDividend,
  input  logic [2:0]  iDivisor,
  output logic [16:0] oQuot,
  output logic        oDone
);

  logic [16:0] quot_q;
  logic [2:0]  rem_q;
  logic [2:0]  div_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  logic [3:0]  rsh;
  logic        ge;
  logic [2:0]  rsub;

  assign rsh  = {rem_q, quot_q[16]};
  assign ge   = rsh >= {1'b0, div_q};
  // When ge holds the difference is below the divisor, so 3 bits suffice.
  assign rsub = rsh[2:0] - div_q;

  always_ff @(posedge clk) begin
    if (!iResetn) begin
      quot_q <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (iStart) begin
        quot_q <= iDividend;
        rem_q  <= '0;
        div_q  <= iDivisor;
        cnt_q  <= 5'd17;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        quot_q <= {quot_q[15:0], ge};
        rem_q  <= ge ? rsub : rsh[2:0];
        cnt_q  <= cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign oQuot = quot_q;
  assign oDone = done_q;

endmodule

// File: rtl/react_test_ctrl.sv
// Reaction-time benchmark sequencer: random WAIT, GO timing, false starts,
// timeouts and a floor average over NUM_TRIALS valid trials.
// Ports: clk, iResetn (sync, low), iEnable, iStart, iPress in;
//   oPhase, oTrial, oTimeMs, oAvgMs, oResultValid, oDone out.
module react_test_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int NUM_TRIALS   = 5,
  parameter int TIMEOUT_MS   = 9999
) (
  input  logic        clk,
  input  logic        iResetn,
  input  logic        iEnable,
  input  logic        iStart,
  input  logic        iPress,
  output logic [2:0]  oPhase,
  output logic [2:0]  oTrial,
  output logic [13:0] oTimeMs,
  output logic [13:0] oAvgMs,
  output logic        oResultValid,
  output logic        oDone
);

  import react_test_ctrl_pkg::*;

  localparam int DIV = CLK_HZ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [13:0] TMO  = 14'(TIMEOUT_MS);
  localparam logic [2:0]  NTR  = 3'(NUM_TRIALS);

  phase_e      state_q, state_d;
  logic [2:0]  trial_q, trial_d;
  logic [16:0] sum_q, sum_d;
  logic [13:0] time_q, time_d;
  logic [13:0] avg_q, avg_d;
  logic [13:0] delay_q, delay_d;
  logic        rv_q, rv_d;
  logic [15:0] lfsr_q;
  logic        start_q, press_q;
  logic [PW-1:0] pre_q;
  logic [13:0] ms_q;

  logic        start_e, press_e;
  logic        tick, wait_exp, go_tout;
  logic        lfsr_fb;
  logic        div_start, div_done;
  logic        div_rstn;
  logic [16:0] div_quot;

  assign start_e  = iStart & ~start_q;
  assign press_e  = iPress & ~press_q;
  assign tick     = (pre_q == PW'(DIV - 1));
  // Expire on the tick that brings the count to the delay: GO lands D ms in.
  assign wait_exp = tick && ((ms_q + 14'd1) >= delay_q);
  assign go_tout  = (ms_q >= TMO);
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    state_d = state_q;
    trial_d = trial_q;
    sum_d   = sum_q;
    time_d  = time_q;
    avg_d   = avg_q;
    delay_d = delay_q;
    rv_d    = 1'b0;
    unique case (state_q)
      PH_IDLE: begin
        if (start_e) state_d = PH_WAIT;
      end
      PH_WAIT: begin
        if (press_e)       state_d = PH_EARLY;
        else if (wait_exp) state_d = PH_GO;
      end
      PH_GO: begin
        // ms_q saturates at TMO, so a timeout records exactly TMO.
        if (press_e || go_tout) begin
          state_d = PH_RESULT;
          time_d  = ms_q;
          sum_d   = sum_q + 17'(ms_q);
          trial_d = trial_q + 3'd1;
          rv_d    = 1'b1;
        end
      end
      PH_RESULT: begin
        if (start_e) state_d = (trial_q == NTR) ? PH_AVG : PH_WAIT;
      end
      PH_EARLY: begin
        if (start_e) state_d = PH_WAIT;
      end
      PH_AVG: begin
        if (div_done) begin
          avg_d   = sat14(div_quot);
          state_d = PH_DONE;
        end
      end
      PH_DONE: begin
        if (start_e) begin
          state_d = PH_IDLE;
          trial_d = '0;
          sum_d   = '0;
          time_d  = '0;
          avg_d   = '0;
        end
      end
      default: state_d = PH_IDLE;
    endcase
    if (state_d == PH_WAIT && state_q != PH_WAIT) begin
      delay_d = 14'(MIN_DELAY_MS) + {3'b000, lfsr_q[10:0]};
    end
    if (!iEnable) begin
      state_d = PH_IDLE;
      trial_d = '0;
      sum_d   = '0;
      time_d  = '0;
      avg_d   = '0;
      rv_d    = 1'b0;
    end
  end

  assign div_start = (state_d == PH_AVG) && (state_q != PH_AVG);
  // Dropping iEnable flushes any division in flight.
  assign div_rstn  = iResetn & iEnable;

  seq_div u_div (
    .clk       (clk),
    .iResetn   (div_rstn),
    .iStart    (div_start),
    .iDividend (sum_q),
    .iDivisor  (NTR),
    .oQuot     (div_quot),
    .oDone     (div_done)
  );

  always_ff @(posedge clk) begin
    if (!iResetn) begin
      state_q <= PH_IDLE;
      trial_q <= '0;
      sum_q   <= '0;
      time_q  <= '0;
      avg_q   <= '0;
      delay_q <= '0;
      rv_q    <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      start_q <= 1'b1;
      press_q <= 1'b1;
      pre_q   <= '0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      trial_q <= trial_d;
      sum_q   <= sum_d;
      time_q  <= time_d;
      avg_q   <= avg_d;
      delay_q <= delay_d;
      rv_q    <= rv_d;
      lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
      start_q <= iStart;
      press_q <= iPress;
      if (state_d != state_q) begin
        pre_q <= '0;
        ms_q  <= '0;
      end else if (tick) begin
        pre_q <= '0;
        if (ms_q < TMO) ms_q <= ms_q + 14'd1;
      end else begin
        pre_q <= pre_q + PW'(1);
      end
    end
  end

  assign oPhase       = state_q;
  assign oTrial       = trial_q;
  assign oTimeMs      = time_q;
  assign oAvgMs       = avg_q;
  assign oResultValid = rv_q;
  assign oDone        = (state_q == PH_DONE);

endmodule

// File: tb/tb_react_test_ctrl.sv
// Directed bench for react_test_ctrl at 1 cycle per ms.
// Covers reset, false start, GO timing, timeout, enable drop and averaging.
module tb_react_test_ctrl;

  localparam logic [2:0] P_IDLE   = 3'd0;
  localparam logic [2:0] P_WAIT   = 3'd1;
  localparam logic [2:0] P_GO     = 3'd2;
  localparam logic [2:0] P_RESULT = 3'd3;
  localparam logic [2:0] P_EARLY  = 3'd4;
  localparam logic [2:0] P_AVG    = 3'd5;
  localparam logic [2:0] P_DONE   = 3'd6;

  logic        clk = 1'b0;
  logic        iResetn, iEnable, iStart, iPress;
  logic [2:0]  oPhase, oTrial;
  logic [13:0] oTimeMs, oAvgMs;
  logic        oResultValid, oDone;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  react_test_ctrl #(.CLK_HZ(1000)) dut (
    .clk          (clk),
    .iResetn      (iResetn),
    .iEnable      (iEnable),
    .iStart       (iStart),
    .iPress       (iPress),
    .oPhase       (oPhase),
    .oTrial       (oTrial),
    .oTimeMs      (oTimeMs),
    .oAvgMs       (oAvgMs),
    .oResultValid (oResultValid),
    .oDone        (oDone)
  );

  initial begin
    #(120_000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic wait_phase(input logic [2:0] ph, input int max,
                            output int n);
    n = 0;
    while (oPhase !== ph && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic press_after(input int c);
    repeat (c) @(negedge clk);
    iPress = 1'b1;
    @(negedge clk);
    iPress = 1'b0;
  endtask

  task automatic run_trial(input int c);
    int n;
    pulse_start();
    wait_phase(P_GO, 3200, n);
    if (oPhase === P_GO) press_after(c);
  endtask

  task automatic test_reset();
    int bad;
    iResetn = 1'b0;
    iEnable = 1'b1;
    iStart  = 1'b1;
    iPress  = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (dut.lfsr_q !== 16'hACE1) begin
      errors++;
      $display("FAIL rst_lfsr: got %h want ace1", dut.lfsr_q);
    end
    iResetn = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (oPhase !== P_IDLE || oResultValid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_hold: %0d bad cycles want 0", bad);
    end
    checks++;
    if (oTrial !== 3'd0 || oTimeMs !== 14'd0 || oAvgMs !== 14'd0
        || oDone !== 1'b0) begin
      errors++;
      $display("FAIL rst_outs: trial %0d time %0d avg %0d done %b want 0",
               oTrial, oTimeMs, oAvgMs, oDone);
    end
    iStart = 1'b0;
    iPress = 1'b0;
    @(negedge clk);
    checks++;
    if (oPhase !== P_IDLE) begin
      errors++;
      $display("FAIL rst_release: phase %0d want %0d", oPhase, P_IDLE);
    end
  endtask

  task automatic test_early();
    pulse_start();
    checks++;
    if (oPhase !== P_WAIT) begin
      errors++;
      $display("FAIL early_wait: phase %0d want %0d", oPhase, P_WAIT);
    end
    press_after(500);
    checks++;
    if (oPhase !== P_EARLY) begin
      errors++;
      $display("FAIL early_phase: phase %0d want %0d", oPhase, P_EARLY);
    end
    checks++;
    if (oTrial !== 3'd0 || oTimeMs !== 14'd0 || oResultValid !== 1'b0) begin
      errors++;
      $display("FAIL early_outs: trial %0d time %0d rv %b want 0 0 0",
               oTrial, oTimeMs, oResultValid);
    end
  endtask

  task automatic test_go_press();
    int d;
    int n;
    pulse_start();
    checks++;
    if (oPhase !== P_WAIT) begin
      errors++;
      $display("FAIL go_rewait: phase %0d want %0d", oPhase, P_WAIT);
    end
    d = int'(dut.delay_q);
    checks++;
    if (d < 1000 || d > 3047) begin
      errors++;
      $display("FAIL go_delay: got %0d want 1000..3047", d);
    end
    wait_phase(P_GO, 3200, n);
    checks++;
    if (oPhase !== P_GO || n != d) begin
      errors++;
      $display("FAIL go_entry: phase %0d after %0d ms want %0d after %0d",
               oPhase, n, P_GO, d);
    end
    press_after(312);
    checks++;
    if (oPhase !== P_RESULT || oTimeMs !== 14'd312 || oTrial !== 3'd1) begin
      errors++;
      $display("FAIL go_result: phase %0d time %0d trial %0d want 3 312 1",
               oPhase, oTimeMs, oTrial);
    end
    checks++;
    if (oResultValid !== 1'b1) begin
      errors++;
      $display("FAIL go_rv_hi: got %b want 1", oResultValid);
    end
    @(negedge clk);
    checks++;
    if (oResultValid !== 1'b0) begin
      errors++;
      $display("FAIL go_rv_lo: got %b want 0", oResultValid);
    end
    press_after(0);
    checks++;
    if (oPhase !== P_RESULT || oTimeMs !== 14'd312 || oTrial !== 3'd1) begin
      errors++;
      $display("FAIL res_press: phase %0d time %0d trial %0d want 3 312 1",
               oPhase, oTimeMs, oTrial);
    end
  endtask

  task automatic test_enable_go();
    int n;
    run_trial(100);
    checks++;
    if (oTrial !== 3'd2 || oTimeMs !== 14'd100) begin
      errors++;
      $display("FAIL en_t2: trial %0d time %0d want 2 100", oTrial, oTimeMs);
    end
    pulse_start();
    wait_phase(P_GO, 3200, n);
    repeat (50) @(negedge clk);
    iEnable = 1'b0;
    @(negedge clk);
    checks++;
    if (oPhase !== P_IDLE || oTrial !== 3'd0 || oTimeMs !== 14'd0
        || oResultValid !== 1'b0) begin
      errors++;
      $display("FAIL en_go: phase %0d trial %0d time %0d rv %b want 0 0 0 0",
               oPhase, oTrial, oTimeMs, oResultValid);
    end
    iEnable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timeout_cancel();
    int n;
    int bad;
    pulse_start();
    wait_phase(P_GO, 3200, n);
    wait_phase(P_RESULT, 10100, n);
    checks++;
    if (oPhase !== P_RESULT || n < 9999 || n > 10000) begin
      errors++;
      $display("FAIL tmo_when: phase %0d after %0d want 3 after 9999..10000",
               oPhase, n);
    end
    checks++;
    if (oTimeMs !== 14'd9999 || oTrial !== 3'd1 || oResultValid !== 1'b1) begin
      errors++;
      $display("FAIL tmo_val: time %0d trial %0d rv %b want 9999 1 1",
               oTimeMs, oTrial, oResultValid);
    end
    run_trial(9999);
    checks++;
    if (oPhase !== P_RESULT || oTimeMs !== 14'd9999 || oTrial !== 3'd2) begin
      errors++;
      $display("FAIL tmo_coinc: phase %0d time %0d trial %0d want 3 9999 2",
               oPhase, oTimeMs, oTrial);
    end
    run_trial(10);
    run_trial(20);
    run_trial(30);
    checks++;
    if (oTrial !== 3'd5 || oTimeMs !== 14'd30) begin
      errors++;
      $display("FAIL tmo_t5: trial %0d time %0d want 5 30", oTrial, oTimeMs);
    end
    pulse_start();
    checks++;
    if (oPhase !== P_AVG) begin
      errors++;
      $display("FAIL cancel_avg: phase %0d want %0d", oPhase, P_AVG);
    end
    repeat (5) @(negedge clk);
    iEnable = 1'b0;
    @(negedge clk);
    checks++;
    if (oPhase !== P_IDLE || oTrial !== 3'd0) begin
      errors++;
      $display("FAIL cancel_idle: phase %0d trial %0d want 0 0",
               oPhase, oTrial);
    end
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (oPhase !== P_IDLE || oAvgMs !== 14'd0 || oDone !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cancel_div: %0d bad cycles want 0", bad);
    end
    iEnable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_average();
    int tt [5] = '{200, 250, 300, 350, 401};
    int n;
    for (int i = 0; i < 5; i++) begin
      run_trial(tt[i]);
      checks++;
      if (oTimeMs !== 14'(tt[i]) || oTrial !== 3'(i + 1)) begin
        errors++;
        $display("FAIL avg_trial%0d: time %0d trial %0d want %0d %0d",
                 i, oTimeMs, oTrial, tt[i], i + 1);
      end
    end
    pulse_start();
    wait_phase(P_DONE, 40, n);
    checks++;
    if (oPhase !== P_DONE || n > 19) begin
      errors++;
      $display("FAIL avg_lat: phase %0d after %0d want 6 within 19",
               oPhase, n);
    end
    checks++;
    if (oAvgMs !== 14'd300 || oDone !== 1'b1 || oTrial !== 3'd5) begin
      errors++;
      $display("FAIL avg_val: avg %0d done %b trial %0d want 300 1 5",
               oAvgMs, oDone, oTrial);
    end
    pulse_start();
    checks++;
    if (oPhase !== P_IDLE || oAvgMs !== 14'd0 || oDone !== 1'b0
        || oTrial !== 3'd0) begin
      errors++;
      $display("FAIL avg_idle: phase %0d avg %0d done %b trial %0d want 0",
               oPhase, oAvgMs, oDone, oTrial);
    end
  endtask

  initial begin
    iResetn = 1'b0;
    iEnable = 1'b1;
    iStart  = 1'b1;
    iPress  = 1'b1;
    @(negedge clk);
    test_reset();
    test_early();
    test_go_press();
    test_enable_go();
    test_timeout_cancel();
    test_average();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
